// File: rtl/cplx_pkg.sv
// Shared widths, data-layout helpers and FSM state type for the complex result accumulator.
package cplx_pkg;

  // Widest bus the layout helpers can handle; one packed product or sum must fit.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } acc_state_e;

  // Width of one signed product component from a DWIDTH-operand complex multiplier.
  function automatic int pwidth(input int dwidth);
    return 2 * (dwidth + 1);
  endfunction

  // Accumulated component width: product width plus headroom for a full frame.
  function automatic int awidth(input int dwidth, input int len_max);
    return pwidth(dwidth) + $clog2(len_max);
  endfunction

  // Sign-extend the low w bits of v to MAX_W bits.
  function automatic logic [MAX_W-1:0] sext(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] shl;
    shl = v << (MAX_W - w);
    return $unsigned($signed(shl) >>> (MAX_W - w));
  endfunction

  // Real part of a {real, imag} bus whose components are w bits each, sign-extended.
  function automatic logic [MAX_W-1:0] split_hi(input logic [MAX_W-1:0] bus, input int w);
    return sext(bus >> w, w);
  endfunction

  // Imaginary part of a {real, imag} bus whose components are w bits each, sign-extended.
  function automatic logic [MAX_W-1:0] split_lo(input logic [MAX_W-1:0] bus, input int w);
    return sext(bus, w);
  endfunction

endpackage

// File: rtl/cplx_res_accumulator_if.sv
// Valid/ready stream carrying a packed {real, imag} complex word.
interface cplx_res_accumulator_if
  import cplx_pkg::*;
#(
  parameter int W = 2 * pwidth(8)
);
  logic         val;
  logic         rdy;
  logic [W-1:0] data;

  modport master (output val, output data, input rdy);
  modport slave  (input val, input data, output rdy);
endinterface

// File: rtl/cplx_acc_lane.sv
// One signed load/accumulate register; the top uses one lane per complex component.
module cplx_acc_lane #(
  parameter int AWIDTH = 22
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     load_i,
  input  logic                     add_i,
  input  logic signed [AWIDTH-1:0] din_i,
  output logic signed [AWIDTH-1:0] sum_o
);

  logic signed [AWIDTH-1:0] acc_q;
  logic signed [AWIDTH-1:0] acc_d;

  // Clear beats load, load beats add; otherwise the running sum holds.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (load_i) begin
      acc_d = din_i;
    end else if (add_i) begin
      acc_d = acc_q + din_i;
    end
  end

  // Running-sum register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign sum_o = acc_q + din_i;

endmodule

// File: rtl/cplx_res_accumulator.sv
// Sums a configurable number of complex products into one complex result on a valid/ready stream.
module cplx_res_accumulator
  import cplx_pkg::*;
#(
  parameter  int DWIDTH      = 8,
  parameter  int ACC_LEN_MAX = 16,
  localparam int AWIDTH      = awidth(DWIDTH, ACC_LEN_MAX),
  localparam int CW          = $clog2(ACC_LEN_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_i,
  input  logic [CW-1:0]         cfg_len_i,
  cplx_res_accumulator_if.slave  res_if,
  cplx_res_accumulator_if.master acc_if,
  output logic                  busy_o
);

  localparam int PWIDTH = pwidth(DWIDTH);

  acc_state_e               state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [CW-1:0]            len_q, len_d;
  logic signed [AWIDTH-1:0] out_re_q, out_re_d;
  logic signed [AWIDTH-1:0] out_im_q, out_im_d;
  logic                     acc_val_q, acc_val_d;
  logic                     rdy_en_q;

  logic                     res_rdy;
  logic                     res_fire;
  logic                     take_first;
  logic [CW-1:0]            eff_len;
  logic signed [AWIDTH-1:0] beat_re, beat_im;
  logic signed [AWIDTH-1:0] sum_re, sum_im;
  logic                     lane_clr, lane_load, lane_add;

  assign beat_re = AWIDTH'(split_hi(MAX_W'(res_if.data), PWIDTH));
  assign beat_im = AWIDTH'(split_lo(MAX_W'(res_if.data), PWIDTH));

  // Frame length as seen on a first beat: zero means one, oversize clamps to the maximum.
  always_comb begin
    eff_len = cfg_len_i;
    if (cfg_len_i == '0) begin
      eff_len = CW'(1);
    end else if (cfg_len_i > CW'(ACC_LEN_MAX)) begin
      eff_len = CW'(ACC_LEN_MAX);
    end
  end

  // Input ready: off until the first clock after reset and during a soft reset; in HOLD it follows downstream ready.
  always_comb begin
    res_rdy = 1'b0;
    if (rdy_en_q && !sw_rst_i) begin
      res_rdy = (state_q == HOLD) ? acc_if.rdy : 1'b1;
    end
  end

  assign res_if.rdy  = res_rdy;
  assign res_fire    = res_if.val && res_rdy;
  assign acc_if.val  = acc_val_q && !sw_rst_i;
  assign acc_if.data = {out_re_q, out_im_q};
  assign busy_o      = (state_q == ACCUM);

  // Next-state logic: soft reset first, then per-state beat handling; a first beat may start in IDLE or in HOLD.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    out_re_d   = out_re_q;
    out_im_d   = out_im_q;
    acc_val_d  = acc_val_q;
    lane_clr   = 1'b0;
    lane_load  = 1'b0;
    lane_add   = 1'b0;
    take_first = 1'b0;

    if (sw_rst_i) begin
      state_d   = IDLE;
      cnt_d     = '0;
      len_d     = '0;
      out_re_d  = '0;
      out_im_d  = '0;
      acc_val_d = 1'b0;
      lane_clr  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          take_first = res_fire;
        end
        ACCUM: begin
          if (res_fire) begin
            lane_add = 1'b1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q + CW'(1) == len_q) begin
              out_re_d  = sum_re;
              out_im_d  = sum_im;
              acc_val_d = 1'b1;
              state_d   = HOLD;
            end
          end
        end
        HOLD: begin
          if (acc_if.rdy) begin
            acc_val_d  = 1'b0;
            state_d    = IDLE;
            take_first = res_fire;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (take_first) begin
        lane_load = 1'b1;
        cnt_d     = CW'(1);
        len_d     = eff_len;
        if (eff_len == CW'(1)) begin
          out_re_d  = beat_re;
          out_im_d  = beat_im;
          acc_val_d = 1'b1;
          state_d   = HOLD;
        end else begin
          state_d = ACCUM;
        end
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      out_re_q  <= '0;
      out_im_q  <= '0;
      acc_val_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      out_re_q  <= out_re_d;
      out_im_q  <= out_im_d;
      acc_val_q <= acc_val_d;
    end
  end

  // Holds input ready low until the first clock after hard reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

  cplx_acc_lane #(.AWIDTH(AWIDTH)) u_lane_re (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (lane_clr),
    .load_i (lane_load),
    .add_i  (lane_add),
    .din_i  (beat_re),
    .sum_o  (sum_re)
  );

  cplx_acc_lane #(.AWIDTH(AWIDTH)) u_lane_im (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (lane_clr),
    .load_i (lane_load),
    .add_i  (lane_add),
    .din_i  (beat_im),
    .sum_o  (sum_im)
  );

endmodule

// File: tb/tb_cplx_res_accumulator.sv
// Directed plus randomized bench for cplx_res_accumulator against a frame-level reference model.
module tb_cplx_res_accumulator;

  localparam int PW = 18;
  localparam int AW = 22;
  localparam int RW = 2 * PW;
  localparam int CW = 5;
  localparam int LMAX = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          swRst = 1'b0;
  logic [CW-1:0] cfgLen = '0;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Reference model: open frame and pending output, described in terms of beats and sums.
  bit pend = 1'b0;
  bit open = 1'b0;
  bit rdyEn = 1'b0;
  bit curArdy = 1'b0;
  bit curSrst = 1'b0;
  int pendRe = 0, pendIm = 0;
  int sumRe = 0, sumIm = 0;
  int cnt = 0, flen = 0;

  cplx_res_accumulator_if #(.W(RW))     resIf ();
  cplx_res_accumulator_if #(.W(2 * AW)) accIf ();

  cplx_res_accumulator #(.DWIDTH(8), .ACC_LEN_MAX(LMAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_rst_i  (swRst),
    .cfg_len_i (cfgLen),
    .res_if    (resIf),
    .acc_if    (accIf),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput();
    logic             expVal, expRdy, expBusy;
    logic [2*AW-1:0]  expData;
    expVal  = pend && !curSrst;
    expRdy  = rdyEn && !curSrst && (!pend || curArdy);
    expBusy = open;
    checks++;
    assert (accIf.val === expVal) else begin
      errors++;
      $error("FAIL acc_val observed=%0b expected=%0b", accIf.val, expVal);
    end
    checks++;
    assert (resIf.rdy === expRdy) else begin
      errors++;
      $error("FAIL res_rdy observed=%0b expected=%0b", resIf.rdy, expRdy);
    end
    checks++;
    assert (busy === expBusy) else begin
      errors++;
      $error("FAIL busy observed=%0b expected=%0b", busy, expBusy);
    end
    if (pend) begin
      expData = {AW'(pendRe), AW'(pendIm)};
      checks++;
      assert (accIf.data === expData) else begin
        errors++;
        $error("FAIL acc_data observed=%h expected=%h", accIf.data, expData);
      end
    end
  endtask

  task automatic modelStep(input bit val, input int re, input int im, input int len, input bit ardy, input bit srst);
    bit expRdy;
    expRdy = rdyEn && !srst && (!pend || ardy);
    if (srst) begin
      pend = 1'b0;
      open = 1'b0;
      sumRe = 0;
      sumIm = 0;
      cnt = 0;
    end else begin
      if (pend && ardy) pend = 1'b0;
      if (val && expRdy) begin
        if (!open) begin
          flen = (len == 0) ? 1 : ((len > LMAX) ? LMAX : len);
          open = 1'b1;
          cnt = 0;
          sumRe = 0;
          sumIm = 0;
        end
        sumRe += re;
        sumIm += im;
        cnt++;
        if (cnt == flen) begin
          pend = 1'b1;
          pendRe = sumRe;
          pendIm = sumIm;
          open = 1'b0;
        end
      end
    end
  endtask

  // One clock: drive at the falling edge, check and advance the model, then let the rising edge happen.
  task automatic applyStimulus(input bit val, input int re, input int im, input int len, input bit ardy, input bit srst);
    @(negedge clk);
    resIf.val  = val;
    resIf.data = {PW'(re), PW'(im)};
    cfgLen     = CW'(len);
    accIf.rdy  = ardy;
    swRst      = srst;
    curArdy    = ardy;
    curSrst    = srst;
    #1;
    checkOutput();
    modelStep(val, re, im, len, ardy, srst);
    @(posedge clk);
    rdyEn = 1'b1;
  endtask

  task automatic checkSum(input int re, input int im);
    logic [2*AW-1:0] want;
    want = {AW'(re), AW'(im)};
    #1;
    checks++;
    assert (accIf.val === 1'b1 && accIf.data === want) else begin
      errors++;
      $error("FAIL frame_sum observed val=%0b data=%h expected val=1 data=%h", accIf.val, accIf.data, want);
    end
  endtask

  task automatic sendFrame(input int n, input int re, input int im, input int len);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, re, im, len, 1'b1, 1'b0);
  endtask

  initial begin
    resIf.val  = 1'b0;
    resIf.data = '0;
    accIf.rdy  = 1'b0;

    // Hard reset: everything quiet, including input ready.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    assert (resIf.rdy === 1'b0 && accIf.val === 1'b0 && busy === 1'b0 && accIf.data === '0) else begin
      errors++;
      $error("FAIL reset_state observed rdy=%0b val=%0b busy=%0b data=%h expected 0 0 0 0",
             resIf.rdy, accIf.val, busy, accIf.data);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b0, 0, 0, 4, 1'b1, 1'b0);

    $display("[TB] four-beat frame");
    applyStimulus(1'b1, 1, -1, 4, 1'b1, 1'b0);
    applyStimulus(1'b1, 2, -1, 4, 1'b1, 1'b0);
    applyStimulus(1'b1, 3, -1, 4, 1'b1, 1'b0);
    applyStimulus(1'b1, 4, -1, 4, 1'b1, 1'b0);
    checkSum(10, -4);
    applyStimulus(1'b0, 0, 0, 4, 1'b1, 1'b0);

    $display("[TB] single-beat frames and zero length");
    applyStimulus(1'b1, -131072, 131071, 1, 1'b1, 1'b0);
    checkSum(-131072, 131071);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, i * 7, -i, 0, 1'b1, 1'b0);
      checkSum(i * 7, -i);
    end
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);

    $display("[TB] full-length frame at extreme values");
    sendFrame(16, 131071, -131072, 16);
    checkSum(2097136, -2097152);
    applyStimulus(1'b0, 0, 0, 16, 1'b1, 1'b0);

    $display("[TB] backpressure then simultaneous handshakes");
    applyStimulus(1'b1, 7, 3, 2, 1'b0, 1'b0);
    applyStimulus(1'b1, -5, 9, 2, 1'b0, 1'b0);
    checkSum(2, 12);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 100, 100, 2, 1'b0, 1'b0);
    checkSum(2, 12);
    applyStimulus(1'b1, 100, 100, 2, 1'b1, 1'b0);
    applyStimulus(1'b1, 1, 1, 2, 1'b1, 1'b0);
    checkSum(101, 101);
    applyStimulus(1'b0, 0, 0, 2, 1'b1, 1'b0);

    $display("[TB] soft reset mid-frame");
    sendFrame(2, 5, 5, 4);
    applyStimulus(1'b1, 9, 9, 4, 1'b1, 1'b1);
    applyStimulus(1'b0, 0, 0, 4, 1'b1, 1'b0);
    sendFrame(4, 5, 5, 4);
    checkSum(20, 20);
    applyStimulus(1'b0, 0, 0, 4, 1'b1, 1'b0);

    $display("[TB] length change mid-frame");
    applyStimulus(1'b1, 1, 0, 4, 1'b1, 1'b0);
    applyStimulus(1'b1, 2, 0, 2, 1'b1, 1'b0);
    applyStimulus(1'b1, 3, 0, 2, 1'b1, 1'b0);
    applyStimulus(1'b1, 4, 0, 2, 1'b1, 1'b0);
    checkSum(10, 0);
    sendFrame(2, 1, 1, 2);
    checkSum(2, 2);
    applyStimulus(1'b0, 0, 0, 2, 1'b1, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    int'($urandom_range(0, 262143)) - 131072,
                    int'($urandom_range(0, 262143)) - 131072,
                    int'($urandom_range(0, 31)),
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 63) == 0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0, 0, 1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
